// File: rtl/sm_reg_dbg_writer.sv
// sm_reg_dbg_writer
// -----------------------------------------------------------------------------
// Board-side debug writer for the sm_top register file. A 32-bit word is built
// nibble by nibble from switches (swNibble) each time btnLoad is pressed. A
// btnCommit press issues a held write request to the core debug write port and
// waits for dbgAck, aborting with an error after ACK_TIMEOUT cycles.
//
// Optional feature macro: SM_DBG_READBACK_EN
//   When defined, a successful write is followed by a readback: regAddr is
//   driven with the written address for one cycle, regData is sampled the next
//   cycle and compared with the written word (match -> done, mismatch -> err).
//   When undefined, regAddr is tied to zero and regData is not used.
//
// Ports:
//   clk        core clock (divided-clock domain of sm_top)
//   rst_p      asynchronous reset, active-high
//   btnLoad    raw pushbutton: shift swNibble into the shadow word
//   btnCommit  raw pushbutton: write shadow word to register swAddr
//   swNibble   nibble to shift in
//   swAddr     target register address
//   dbgWe      write request, held until dbgAck or timeout
//   dbgAddr    write address, frozen while dbgWe=1
//   dbgWData   write data, frozen while dbgWe=1
//   dbgAck     one-cycle write acknowledge from the core
//   regAddr    readback address (readback feature only, else 0)
//   regData    readback data from the sm_top read port
//   nibCnt     nibbles loaded, saturating at DATA_W/4
//   busy       high whenever the writer is not idle
//   done       one-cycle pulse on successful completion
//   err        sticky error flag (reg 0 target, ack timeout, readback mismatch)
// -----------------------------------------------------------------------------
module sm_reg_dbg_writer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 32,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_p,
  input  logic                          btnLoad,
  input  logic                          btnCommit,
  input  logic [3:0]                    swNibble,
  input  logic [ADDR_W-1:0]             swAddr,
  output logic                          dbgWe,
  output logic [ADDR_W-1:0]             dbgAddr,
  output logic [DATA_W-1:0]             dbgWData,
  input  logic                          dbgAck,
  output logic [ADDR_W-1:0]             regAddr,
  input  logic [DATA_W-1:0]             regData,
  output logic [$clog2(DATA_W/4+1)-1:0] nibCnt,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int NIB = DATA_W / 4;
  localparam int NCW = $clog2(NIB + 1);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [NCW-1:0] NIB_MAX = NCW'(NIB);
  localparam logic [NCW-1:0] NIB_ONE = NCW'(32'd1);
  localparam logic [DCW-1:0] DEB_MAX = DCW'(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DEB_M1  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCW-1:0] DEB_ONE = DCW'(32'd1);
  localparam logic [TW-1:0]  TMO_M1  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]  TMO_ONE = TW'(32'd1);

  // Button index within the debounce arrays.
  localparam int B_LOAD   = 0;
  localparam int B_COMMIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CHECK  = 2'd2,
    ST_VERIFY = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0][DCW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]          lvl_q, lvl_d;
  logic [1:0]          pulse_q, pulse_d;

  logic load_pulse_s;
  logic commit_pulse_s;

  // Debounce: count consecutive synced-high cycles, one pulse per accepted press.
  always_comb begin
    sync1_d   = {btnCommit, btnLoad};
    sync2_d   = sync1_q;
    deb_cnt_d = '0;
    lvl_d     = 2'b00;
    pulse_d   = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b]) begin
        if (deb_cnt_q[b] == DEB_MAX) begin
          deb_cnt_d[b] = deb_cnt_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_ONE;
        end
        // The level rises on the cycle that completes the stable run.
        lvl_d[b] = (deb_cnt_q[b] >= DEB_M1);
      end else begin
        deb_cnt_d[b] = '0;
        lvl_d[b]     = 1'b0;
      end
      pulse_d[b] = lvl_d[b] & ~lvl_q[b];
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      deb_cnt_q <= '0;
      lvl_q     <= 2'b00;
      pulse_q   <= 2'b00;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      lvl_q     <= lvl_d;
      pulse_q   <= pulse_d;
    end
  end

  assign load_pulse_s   = pulse_q[B_LOAD];
  assign commit_pulse_s = pulse_q[B_COMMIT];

  // ---------------------------------------------------------------------------
  // Write sequencer
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [NCW-1:0]      nib_cnt_q, nib_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef SM_DBG_READBACK_EN
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
`endif

  // Next-state and output computation for the write sequencer.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    nib_cnt_d = nib_cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef SM_DBG_READBACK_EN
    reg_addr_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Commit has priority; a load on the same cycle is dropped.
        if (commit_pulse_s) begin
          if (swAddr == '0) begin
            // Register 0 is hardwired zero, so refuse the write.
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            addr_d  = swAddr;
            wdata_d = shadow_q;
            we_d    = 1'b1;
            tmo_d   = '0;
            state_d = ST_REQ;
          end
        end else if (load_pulse_s) begin
          shadow_d = {shadow_q[DATA_W-5:0], swNibble};
          if (nib_cnt_q == NIB_MAX) begin
            nib_cnt_d = nib_cnt_q;
          end else begin
            nib_cnt_d = nib_cnt_q + NIB_ONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (dbgAck) begin
          we_d      = 1'b0;
          shadow_d  = '0;
          nib_cnt_d = '0;
          tmo_d     = '0;
`ifdef SM_DBG_READBACK_EN
          reg_addr_d = addr_q;
          state_d    = ST_CHECK;
`else
          done_d     = 1'b1;
          state_d    = ST_IDLE;
`endif
        end else if (tmo_q == TMO_M1) begin
          // No ack in time: abort but keep the shadow word for a retry.
          we_d    = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

`ifdef SM_DBG_READBACK_EN
      ST_CHECK: begin
        // regAddr was presented this cycle; read data is taken next cycle.
        state_d = ST_VERIFY;
      end

      ST_VERIFY: begin
        if (regData == wdata_q) begin
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
`endif

      default: begin
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Write sequencer registers, including the registered outputs.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      nib_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      nib_cnt_q <= nib_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef SM_DBG_READBACK_EN
  // Readback address register, non-zero only during the check cycle.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      reg_addr_q <= '0;
    end else begin
      reg_addr_q <= reg_addr_d;
    end
  end

  assign regAddr = reg_addr_q;
`else
  logic unused_regdata_s;
  assign unused_regdata_s = ^regData;
  assign regAddr          = '0;
`endif

  assign dbgWe    = we_q;
  assign dbgAddr  = addr_q;
  assign dbgWData = wdata_q;
  assign nibCnt   = nib_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sm_reg_dbg_writer.sv
// Testbench for sm_reg_dbg_writer: randomized button/ack stimulus compared on
// every cycle against a behavioural model, plus directed scenarios with
// hand-computed expectations.
module tb_sm_reg_dbg_writer;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        btnLoad = 1'b0;
  logic        btnCommit = 1'b0;
  logic [3:0]  swNibble = 4'd0;
  logic [4:0]  swAddr = 5'd0;
  logic        dbgWe;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgWData;
  logic        dbgAck = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData = 32'd0;
  logic [3:0]  nibCnt;
  logic        busy;
  logic        done;
  logic        err;

  sm_reg_dbg_writer #(
    .DEBOUNCE_CYCLES(DEB),
    .ADDR_W(5),
    .DATA_W(32),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_p(rst_p), .btnLoad(btnLoad), .btnCommit(btnCommit),
    .swNibble(swNibble), .swAddr(swAddr), .dbgWe(dbgWe), .dbgAddr(dbgAddr),
    .dbgWData(dbgWData), .dbgAck(dbgAck), .regAddr(regAddr), .regData(regData),
    .nibCnt(nibCnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  int ack_after = 0;   // 0: never acknowledge
  int done_cnt = 0;
  int ra_cnt = 0;
  int we_cycles = 0;

  // ---------------- behavioural model ----------------
  int          m_run_l = 0, m_run_c = 0;
  bit          m_pl [3];
  bit          m_pc [3];
  int          m_phase = 0;   // 0 idle, 1 request, 2 show address, 3 compare
  logic [31:0] m_shadow = 32'd0, m_data = 32'd0;
  logic [4:0]  m_addr = 5'd0;
  int          m_nib = 0, m_wait = 0;
  bit          m_we = 1'b0, m_done = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run_l = 0; m_run_c = 0;
    for (int i = 0; i < 3; i++) begin m_pl[i] = 1'b0; m_pc[i] = 1'b0; end
    m_phase = 0; m_shadow = 32'd0; m_data = 32'd0; m_addr = 5'd0;
    m_nib = 0; m_wait = 0; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst_p);
      if (rst_p) begin
        model_reset();
      end else begin
        bit act_l, act_c;
        // A press is accepted once DEB consecutive high samples are seen;
        // the sequencer acts on it three edges later.
        act_l = m_pl[2]; act_c = m_pc[2];
        m_pl[2] = m_pl[1]; m_pl[1] = m_pl[0];
        m_pc[2] = m_pc[1]; m_pc[1] = m_pc[0];
        m_run_l = btnLoad ? m_run_l + 1 : 0;
        m_run_c = btnCommit ? m_run_c + 1 : 0;
        m_pl[0] = (m_run_l == DEB);
        m_pc[0] = (m_run_c == DEB);
        m_done = 1'b0;
        case (m_phase)
          0: begin
            if (act_c) begin
              if (swAddr == 5'd0) m_err = 1'b1;
              else begin
                m_err = 1'b0; m_addr = swAddr; m_data = m_shadow;
                m_we = 1'b1; m_wait = 0; m_phase = 1;
              end
            end else if (act_l) begin
              m_shadow = (m_shadow << 4) | {28'd0, swNibble};
              if (m_nib < 8) m_nib++;
            end
          end
          1: begin
            if (dbgAck) begin
              m_we = 1'b0; m_shadow = 32'd0; m_nib = 0;
`ifdef SM_DBG_READBACK_EN
              m_phase = 2;
`else
              m_phase = 0; m_done = 1'b1;
`endif
            end else begin
              m_wait++;
              if (m_wait == TMO) begin m_we = 1'b0; m_err = 1'b1; m_phase = 0; end
            end
          end
          2: m_phase = 3;
          3: begin
            if (regData == m_data) m_done = 1'b1;
            else m_err = 1'b1;
            m_phase = 0;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("dbgWe", {31'd0, dbgWe}, {31'd0, m_we});
        chk("dbgAddr", {27'd0, dbgAddr}, {27'd0, m_addr});
        chk("dbgWData", dbgWData, m_data);
        chk("nibCnt", {28'd0, nibCnt}, 32'(m_nib));
        chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("regAddr", {27'd0, regAddr}, (m_phase == 2) ? {27'd0, m_addr} : 32'd0);
      end
      if (done === 1'b1) done_cnt++;
      if (regAddr === 5'd7) ra_cnt++;
      if (dbgWe === 1'b1) we_cycles++;
    end
  end

  // Core responder: pulse dbgAck after dbgWe has been high ack_after cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (dbgWe && !dbgAck && ack_after > 0) begin
        cnt++;
        if (cnt == ack_after) dbgAck = 1'b1;
      end else begin
        dbgAck = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // which: 0 load, 1 commit, 2 both at once
  task automatic press(input int which, input logic [3:0] nib, input logic [4:0] addr,
                       input int hold, input int gap);
    if (which != 1) begin swNibble = nib; btnLoad = 1'b1; end
    if (which != 0) begin swAddr = addr; btnCommit = 1'b1; end
    repeat (hold) tick();
    if (which != 1) btnLoad = 1'b0;
    if (which != 0) btnCommit = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int d0, w0;
    logic [31:0] word;
    rst_p = 1'b1;
    tick();
    cmp_en = 1'b1;
    repeat (2) tick();
    chk("rst_dbgWe", {31'd0, dbgWe}, 32'd0);
    chk("rst_nibCnt", {28'd0, nibCnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_p = 1'b0;
    tick();

    // Eight loads 1..8, then a short glitch that must not shift.
    for (int i = 1; i <= 8; i++) press(0, 4'(i), 5'd0, 10, 6);
    chk("load_nibCnt", {28'd0, nibCnt}, 32'd8);
    chk("model_shadow", m_shadow, 32'h12345678);
    press(0, 4'hF, 5'd0, 3, 8);
    chk("glitch_nibCnt", {28'd0, nibCnt}, 32'd8);
    chk("glitch_shadow", m_shadow, 32'h12345678);

    // Commit to r5, core acks after 3 cycles.
    ack_after = 3; d0 = done_cnt; w0 = we_cycles;
    press(1, 4'd0, 5'd5, 10, 6);
    chk("wr_addr", {27'd0, dbgAddr}, 32'd5);
    chk("wr_data", dbgWData, 32'h12345678);
    chk("wr_we_cycles", 32'(we_cycles - w0), 32'd3);
    chk("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("wr_nibCnt", {28'd0, nibCnt}, 32'd0);

    // Commit to r0 is refused; a valid commit clears err.
    press(1, 4'd0, 5'd0, 10, 6);
    chk("r0_err", {31'd0, err}, 32'd1);
    chk("r0_busy", {31'd0, busy}, 32'd0);
    chk("r0_we", {31'd0, dbgWe}, 32'd0);
    ack_after = 2;
    press(1, 4'd0, 5'd3, 10, 6);
    chk("clr_err", {31'd0, err}, 32'd0);

    // Timeout with a load press landing during REQ.
    press(0, 4'hC, 5'd0, 8, 4);
    press(0, 4'h3, 5'd0, 8, 4);
    ack_after = 0;
    fork
      press(1, 4'd0, 5'd9, 10, 8);
      begin repeat (7) tick(); press(0, 4'h7, 5'd0, 6, 2); end
    join
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_we", {31'd0, dbgWe}, 32'd0);
    chk("tmo_nibCnt", {28'd0, nibCnt}, 32'd2);
    ack_after = 2;
    press(1, 4'd0, 5'd9, 10, 6);
    chk("retry_data", dbgWData, 32'h000000C3);
    chk("retry_err", {31'd0, err}, 32'd0);

`ifdef SM_DBG_READBACK_EN
    word = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) press(0, word[31-4*i -: 4], 5'd0, 8, 4);
    regData = 32'hDEADBEEF; ack_after = 1; d0 = done_cnt; w0 = ra_cnt;
    press(1, 4'd0, 5'd7, 10, 8);
    chk("rb_done", 32'(done_cnt - d0), 32'd1);
    chk("rb_regAddr_cycles", 32'(ra_cnt - w0), 32'd1);
    chk("rb_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 8; i++) press(0, word[31-4*i -: 4], 5'd0, 8, 4);
    regData = 32'hDEADBEEE; d0 = done_cnt;
    press(1, 4'd0, 5'd7, 10, 8);
    chk("rb_bad_err", {31'd0, err}, 32'd1);
    chk("rb_bad_done", 32'(done_cnt - d0), 32'd0);
`else
    word = 32'd0;
`endif

    // Randomized phase.
    for (int it = 0; it < 90; it++) begin
      int kind;
      logic [3:0] n;
      logic [4:0] a;
      kind = int'($urandom_range(0, 9));
      n = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      regData = ($urandom_range(0, 1) == 0) ? m_shadow : $urandom;
      if (kind <= 5) begin
        press(0, n, 5'd0, int'($urandom_range(1, 9)), int'($urandom_range(1, 5)));
      end else if (kind <= 8) begin
        ack_after = int'($urandom_range(0, 10));
        press(1, n, a, int'($urandom_range(3, 10)), int'($urandom_range(1, 14)));
      end else begin
        ack_after = int'($urandom_range(1, 5));
        press(2, n, a, int'($urandom_range(4, 9)), 14);
      end
    end
    repeat (20) tick();

    // Asynchronous reset in the middle of a request.
    press(0, 4'h5, 5'd0, 8, 4);
    ack_after = 0;
    press(1, 4'd0, 5'd4, 10, 0);
    chk("pre_rst_we", {31'd0, dbgWe}, 32'd1);
    @(posedge clk); #3;
    rst_p = 1'b1;
    #1;
    chk("async_rst_we", {31'd0, dbgWe}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_nibCnt", {28'd0, nibCnt}, 32'd0);
    repeat (2) tick();
    rst_p = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
